// File: rtl/svm_modality_sequencer.sv
// svm_modality_sequencer
// Feeds valence and arousal feature vectors from two independent upstream
// channels into the single SVM input port. Each entry is sent valence first,
// then arousal. The block limits the number of entries in flight inside the
// SVM, tags each entry with a wrapping ID, and passes SVM results downstream
// with the matching ID.
//
// Optional feature: define SVM_SEQ_PERF_EN to enable the latency monitor.
// Each entry is timestamped with a free-running cycle counter when its
// valence vector is accepted. While a result is valid, dout_latency reports
// the elapsed cycles. Without the macro, dout_latency is tied to zero.
module svm_modality_sequencer #(
  parameter int NBITS       = 16,
  parameter int F_WIDTH     = 16,
  parameter int MAX_OUT     = 4,
  parameter int LOG_MAX_OUT = 2,
  parameter int ID_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBITS*F_WIDTH-1:0] v_in_features,
  input  logic                     v_in_valid,
  output logic                     v_in_ready,
  input  logic [NBITS*F_WIDTH-1:0] a_in_features,
  input  logic                     a_in_valid,
  output logic                     a_in_ready,
  output logic [NBITS*F_WIDTH-1:0] svm_features,
  output logic                     svm_fin_valid,
  input  logic                     svm_fin_ready,
  input  logic                     svm_valence,
  input  logic                     svm_arousal,
  input  logic                     svm_dout_valid,
  output logic                     svm_dout_ready,
  output logic                     valence,
  output logic                     arousal,
  output logic [ID_BITS-1:0]       dout_id,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [LOG_MAX_OUT:0]     outstanding,
  output logic                     err,
  output logic [31:0]              dout_latency
);

  localparam int VW = NBITS * F_WIDTH;
  localparam logic [LOG_MAX_OUT:0]   MAX_C   = (LOG_MAX_OUT+1)'(MAX_OUT);
  localparam logic [LOG_MAX_OUT:0]   CNT_ONE = (LOG_MAX_OUT+1)'(1);
  localparam logic [LOG_MAX_OUT-1:0] PTR_ONE = LOG_MAX_OUT'(1);
  localparam logic [ID_BITS-1:0]     ID_ONE  = ID_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_V = 2'd1,
    ST_LOAD_A = 2'd2,
    ST_SEND_A = 2'd3
  } state_t;

  state_t                 state_r;
  logic [VW-1:0]          feat_r;
  logic                   fin_valid_r;
  logic                   v_ready_r;
  logic                   a_ready_r;
  logic [ID_BITS-1:0]     next_id_r;
  logic [LOG_MAX_OUT:0]   outstanding_r;
  logic                   err_r;
  logic [LOG_MAX_OUT-1:0] wr_ptr_r;
  logic [LOG_MAX_OUT-1:0] rd_ptr_r;
  logic [ID_BITS-1:0]     tag_mem_r [MAX_OUT];

  logic                   v_hs_s;
  logic                   a_hs_s;
  logic                   issue_s;
  logic                   empty_s;
  logic                   pop_s;
  logic                   spur_s;
  logic [LOG_MAX_OUT:0]   cnt_next_s;

  assign v_hs_s  = v_in_valid & v_ready_r;
  assign a_hs_s  = a_in_valid & a_ready_r;
  // An entry is committed when the SVM accepts its arousal vector.
  assign issue_s = fin_valid_r & svm_fin_ready & (state_r == ST_SEND_A);
  assign empty_s = (outstanding_r == {(LOG_MAX_OUT+1){1'b0}});
  // A result with no tag behind it is a protocol error, not a pop.
  assign pop_s   = svm_dout_valid & dout_ready & ~empty_s;
  assign spur_s  = svm_dout_valid & empty_s;

  // Next in-flight count: an issue and a pop in the same cycle cancel out.
  always_comb begin
    cnt_next_s = outstanding_r;
    case ({issue_s, pop_s})
      2'b10:   cnt_next_s = outstanding_r + CNT_ONE;
      2'b01:   cnt_next_s = outstanding_r - CNT_ONE;
      default: cnt_next_s = outstanding_r;
    endcase
  end

  // Entry sequencer: capture valence, issue it, capture arousal, issue it.
  // v_in_ready is registered from the next count, so freeing a credit
  // re-opens the valence input one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      feat_r      <= {VW{1'b0}};
      fin_valid_r <= 1'b0;
      v_ready_r   <= 1'b1;
      a_ready_r   <= 1'b0;
      next_id_r   <= {ID_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (v_hs_s) begin
            feat_r      <= v_in_features;
            fin_valid_r <= 1'b1;
            v_ready_r   <= 1'b0;
            state_r     <= ST_SEND_V;
          end else begin
            v_ready_r   <= (cnt_next_s < MAX_C);
          end
        end
        ST_SEND_V: begin
          if (svm_fin_ready) begin
            fin_valid_r <= 1'b0;
            a_ready_r   <= 1'b1;
            state_r     <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (a_hs_s) begin
            feat_r      <= a_in_features;
            a_ready_r   <= 1'b0;
            fin_valid_r <= 1'b1;
            state_r     <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (svm_fin_ready) begin
            fin_valid_r <= 1'b0;
            v_ready_r   <= (cnt_next_s < MAX_C);
            next_id_r   <= next_id_r + ID_ONE;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          fin_valid_r <= 1'b0;
          v_ready_r   <= 1'b0;
          a_ready_r   <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag FIFO pointers, in-flight count and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= {LOG_MAX_OUT{1'b0}};
      rd_ptr_r      <= {LOG_MAX_OUT{1'b0}};
      outstanding_r <= {(LOG_MAX_OUT+1){1'b0}};
      err_r         <= 1'b0;
    end else begin
      if (issue_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      outstanding_r <= cnt_next_s;
      if (spur_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Tag storage: contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      tag_mem_r[wr_ptr_r] <= next_id_r;
    end
  end

  assign svm_features   = feat_r;
  assign svm_fin_valid  = fin_valid_r;
  assign v_in_ready     = v_ready_r;
  assign a_in_ready     = a_ready_r;
  assign outstanding    = outstanding_r;
  assign err            = err_r;

  // Result path is a pure pass-through, tagged from the FIFO head.
  assign valence        = svm_valence;
  assign arousal        = svm_arousal;
  assign dout_valid     = svm_dout_valid;
  assign svm_dout_ready = dout_ready;
  assign dout_id        = empty_s ? {ID_BITS{1'b0}} : tag_mem_r[rd_ptr_r];

`ifdef SVM_SEQ_PERF_EN
  logic [31:0] cycle_r;
  logic [31:0] ts_pend_r;
  logic [31:0] ts_mem_r [MAX_OUT];

  // Free-running cycle counter and capture of the valence issue time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_r   <= 32'd0;
      ts_pend_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
      if (fin_valid_r && svm_fin_ready && (state_r == ST_SEND_V)) begin
        ts_pend_r <= cycle_r;
      end
    end
  end

  // Timestamp FIFO written alongside the tag FIFO.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      ts_mem_r[wr_ptr_r] <= ts_pend_r;
    end
  end

  assign dout_latency = (svm_dout_valid && !empty_s) ? (cycle_r - ts_mem_r[rd_ptr_r]) : 32'd0;
`else
  assign dout_latency = 32'd0;
`endif

endmodule

// File: tb/tb_svm_modality_sequencer.sv
// Self-checking bench for svm_modality_sequencer. A table of entries is
// applied in a loop. Hand-written sequences then cover credit limits,
// stalls, ID wrap, spurious results and mid-operation reset. The expected
// features and tagged results are queued when the stimulus is driven, and
// compared when the DUT produces them.
module tb_svm_modality_sequencer;
  localparam int NBITS       = 16;
  localparam int F_WIDTH     = 16;
  localparam int MAX_OUT     = 4;
  localparam int LOG_MAX_OUT = 2;
  localparam int ID_BITS     = 8;
  localparam int VW          = NBITS * F_WIDTH;
`ifdef SVM_SEQ_PERF_EN
  localparam bit PERF    = 1'b1;
  localparam int SVM_LAT = 37;
`else
  localparam bit PERF    = 1'b0;
  localparam int SVM_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [VW-1:0] v_in_features = '0;
  logic v_in_valid = 1'b0;
  logic v_in_ready;
  logic [VW-1:0] a_in_features = '0;
  logic a_in_valid = 1'b0;
  logic a_in_ready;
  logic [VW-1:0] svm_features;
  logic svm_fin_valid;
  logic svm_fin_ready = 1'b0;
  logic svm_valence = 1'b0;
  logic svm_arousal = 1'b0;
  logic svm_dout_valid = 1'b0;
  logic svm_dout_ready;
  logic valence, arousal;
  logic [ID_BITS-1:0] dout_id;
  logic dout_valid;
  logic dout_ready = 1'b1;
  logic [LOG_MAX_OUT:0] outstanding;
  logic err;
  logic [31:0] dout_latency;

  svm_modality_sequencer #(
    .NBITS(NBITS), .F_WIDTH(F_WIDTH), .MAX_OUT(MAX_OUT),
    .LOG_MAX_OUT(LOG_MAX_OUT), .ID_BITS(ID_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .v_in_features(v_in_features), .v_in_valid(v_in_valid), .v_in_ready(v_in_ready),
    .a_in_features(a_in_features), .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
    .svm_features(svm_features), .svm_fin_valid(svm_fin_valid), .svm_fin_ready(svm_fin_ready),
    .svm_valence(svm_valence), .svm_arousal(svm_arousal),
    .svm_dout_valid(svm_dout_valid), .svm_dout_ready(svm_dout_ready),
    .valence(valence), .arousal(arousal), .dout_id(dout_id),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .outstanding(outstanding), .err(err), .dout_latency(dout_latency)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct { logic [ID_BITS-1:0] id; logic val; logic aro; } res_t;
  typedef struct { logic val; logic aro; int unsigned vcyc; } svm_t;
  typedef struct { logic [15:0] ve; logic [15:0] ae; int lead; logic ev; logic ea; } vec_t;

  res_t        sb_q[$];
  logic [VW-1:0] feat_q[$];
  svm_t        svm_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [ID_BITS-1:0] exp_id = '0;
  bit  svm_phase = 1'b0;
  logic v_label = 1'b0;
  int unsigned v_cyc = 0;
  int  ret_budget = 0;
  bit  fin_ready_en = 1'b1;
  bit  spur = 1'b0;
  bit  drv_real = 1'b0;
  int unsigned last_pop_cyc = 0;
  int unsigned last_vhs_cyc = 0;
  logic v_ready_at_pop = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [VW-1:0] rep(input logic [15:0] e);
    return {F_WIDTH{e}};
  endfunction

  task automatic to_sample(); @(negedge clk); #4; endtask
  task automatic to_drive();  @(posedge clk); #1; endtask
  task automatic tick(input int n); repeat (n) to_drive(); endtask

  // SVM model and output monitor: samples handshakes just before each edge,
  // then updates the model's outputs shortly after the edge.
  initial begin
    forever begin
      to_sample();
      if (!rst) begin
        if (svm_fin_valid && svm_fin_ready) begin
          if (feat_q.size() == 0) fail_now("unexpected_fin");
          else chk_vec("svm_features", svm_features, feat_q.pop_front());
          if (!svm_phase) begin
            v_label = svm_features[NBITS-1];
            v_cyc = cyc;
            svm_phase = 1'b1;
          end else begin
            svm_q.push_back('{val: v_label, aro: svm_features[NBITS-1], vcyc: v_cyc});
            svm_phase = 1'b0;
          end
        end
        if (v_in_valid && v_in_ready) last_vhs_cyc = cyc;
        if (dout_valid && dout_ready) begin
          if (drv_real && svm_q.size() > 0 && sb_q.size() > 0) begin
            res_t e;
            svm_t h;
            e = sb_q.pop_front();
            h = svm_q.pop_front();
            chk("dout_id", dout_id, e.id);
            chk("valence", valence, e.val);
            chk("arousal", arousal, e.aro);
            chk("dout_latency", dout_latency, PERF ? 64'(cyc - h.vcyc) : 64'd0);
            last_pop_cyc = cyc;
            v_ready_at_pop = v_in_ready;
            ret_budget--;
          end else if (spur) begin
            chk("spur_dout_id", dout_id, 0);
            chk("spur_outstanding", outstanding, 0);
          end else begin
            fail_now("unexpected_dout");
          end
        end
      end
      @(posedge clk); #2;
      svm_fin_ready = fin_ready_en;
      drv_real = (svm_q.size() > 0) && (ret_budget > 0) && ((cyc - svm_q[0].vcyc) >= SVM_LAT);
      svm_dout_valid = drv_real || spur;
      svm_valence = drv_real ? svm_q[0].val : 1'b1;
      svm_arousal = drv_real ? svm_q[0].aro : 1'b1;
    end
  end

  // Offer one entry; the arousal vector may be raised 'lead' cycles early.
  task automatic send_entry(input logic [15:0] ve, input logic [15:0] ae, input int lead,
                            input logic ev, input logic ea);
    bit vd, ad, vh, ah;
    sb_q.push_back('{id: exp_id, val: ev, aro: ea});
    exp_id++;
    feat_q.push_back(rep(ve));
    feat_q.push_back(rep(ae));
    a_in_features = rep(ae);
    if (lead > 0) a_in_valid = 1'b1;
    for (int i = 0; i < lead; i++) begin
      to_sample();
      chk("a_ready_early", a_in_ready, 0);
      to_drive();
    end
    v_in_features = rep(ve);
    v_in_valid = 1'b1;
    a_in_valid = 1'b1;
    vd = 1'b0;
    ad = 1'b0;
    for (int i = 0; i < 400 && !(vd && ad); i++) begin
      to_sample();
      vh = v_in_valid && v_in_ready;
      ah = a_in_valid && a_in_ready;
      if (ah && !vd) fail_now("a_before_v");
      to_drive();
      if (vh) begin v_in_valid = 1'b0; vd = 1'b1; end
      if (ah) begin a_in_valid = 1'b0; ad = 1'b1; end
    end
    if (!(vd && ad)) begin
      fail_now("entry_timeout");
      v_in_valid = 1'b0;
      a_in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 2000 && sb_q.size() > 0; i++) to_drive();
    if (sb_q.size() > 0) fail_now("drain_timeout");
    tick(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [VW-1:0] held;
    bit seen;
    tbl[0] = '{ve: 16'h0001, ae: 16'h0002, lead: 0, ev: 1'b0, ea: 1'b0};
    tbl[1] = '{ve: 16'h8000, ae: 16'h0003, lead: 0, ev: 1'b1, ea: 1'b0};
    tbl[2] = '{ve: 16'h1234, ae: 16'hF00D, lead: 3, ev: 1'b0, ea: 1'b1};
    tbl[3] = '{ve: 16'hFFFF, ae: 16'h8001, lead: 1, ev: 1'b1, ea: 1'b1};
    tbl[4] = '{ve: 16'h7FFF, ae: 16'h0000, lead: 2, ev: 1'b0, ea: 1'b0};
    tbl[5] = '{ve: 16'hA5A5, ae: 16'h5A5A, lead: 0, ev: 1'b1, ea: 1'b0};

    // Reset values.
    tick(3);
    to_sample();
    chk("rst_fin_valid", svm_fin_valid, 0);
    chk("rst_v_ready", v_in_ready, 1);
    chk("rst_a_ready", a_in_ready, 0);
    chk_vec("rst_features", svm_features, '0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_latency", dout_latency, 0);
    to_drive();
    rst = 1'b0;
    tick(1);

    // Single entry: outstanding goes 0 -> 1 -> 0, id 0.
    ret_budget = 0;
    send_entry(16'h0001, 16'h0002, 0, 1'b0, 1'b0);
    tick(2);
    to_sample();
    chk("single_outstanding_1", outstanding, 1);
    to_drive();
    ret_budget = 1000;
    wait_drain();
    to_sample();
    chk("single_outstanding_0", outstanding, 0);
    to_drive();

    // Table-driven entries, some with arousal offered early.
    for (int i = 0; i < 6; i++) send_entry(tbl[i].ve, tbl[i].ae, tbl[i].lead, tbl[i].ev, tbl[i].ea);
    wait_drain();

    // Credit limit: four in flight block the fifth until one result pops.
    ret_budget = 0;
    for (int i = 0; i < 4; i++) send_entry(16'h0100 + 16'(i), 16'h8100 + 16'(i), 0, 1'b0, 1'b1);
    tick(3);
    to_sample();
    chk("credit_outstanding", outstanding, 4);
    chk("credit_v_ready", v_in_ready, 0);
    to_drive();
    fork
      send_entry(16'h9999, 16'h1111, 0, 1'b1, 1'b0);
      begin tick(4); ret_budget = 1; end
    join
    chk("credit_gap", last_vhs_cyc - last_pop_cyc, 1);
    chk("credit_ready_at_pop", v_ready_at_pop, 0);
    ret_budget = 1000;
    wait_drain();

    // Stall in SEND_V, then downstream backpressure with three results.
    ret_budget = 0;
    fin_ready_en = 1'b0;
    fork
      send_entry(16'h4242, 16'hC3C3, 0, 1'b0, 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          to_sample();
          seen = svm_fin_valid;
          held = svm_features;
          if (!seen) to_drive();
        end
        if (!seen) fail_now("stall_no_valid");
        for (int i = 0; i < 7; i++) begin
          to_drive();
          to_sample();
          chk("stall_valid", svm_fin_valid, 1);
          chk_vec("stall_features", svm_features, held);
        end
        to_drive();
        fin_ready_en = 1'b1;
      end
    join
    send_entry(16'h0042, 16'h8042, 0, 1'b0, 1'b1);
    send_entry(16'h8043, 16'h0043, 0, 1'b1, 1'b0);
    tick(SVM_LAT + 4);
    dout_ready = 1'b0;
    ret_budget = 1000;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      to_sample();
      chk("bp_dout_valid", dout_valid, 1);
      chk("bp_outstanding", outstanding, 3);
      chk("bp_dout_id", dout_id, sb_q[0].id);
      to_drive();
    end
    dout_ready = 1'b1;
    wait_drain();

    // ID wrap: stream enough entries to pass 2^ID_BITS.
    for (int i = 0; i < 260; i++) begin
      logic [15:0] ve, ae;
      ve = 16'(i * 16'h0123);
      ae = ~ve;
      send_entry(ve, ae, 0, ve[15], ae[15]);
    end
    wait_drain();

    // Spurious result with nothing in flight sets a sticky error.
    to_sample();
    chk("pre_spur_outstanding", outstanding, 0);
    chk("pre_spur_err", err, 0);
    to_drive();
    spur = 1'b1;
    to_drive();
    spur = 1'b0;
    tick(2);
    to_sample();
    chk("spur_err_set", err, 1);
    to_drive();
    send_entry(16'h0777, 16'h8777, 0, 1'b0, 1'b1);
    wait_drain();
    to_sample();
    chk("err_sticky", err, 1);
    to_drive();

    // Reset mid-entry discards the captured vector and clears everything.
    fin_ready_en = 1'b0;
    v_in_features = rep(16'h5555);
    v_in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      to_sample();
      seen = svm_fin_valid;
      to_drive();
    end
    if (!seen) fail_now("midrst_no_valid");
    v_in_valid = 1'b0;
    rst = 1'b1;
    feat_q.delete();
    svm_q.delete();
    sb_q.delete();
    svm_phase = 1'b0;
    exp_id = '0;
    to_drive();
    to_sample();
    chk("midrst_fin_valid", svm_fin_valid, 0);
    chk_vec("midrst_features", svm_features, '0);
    chk("midrst_v_ready", v_in_ready, 1);
    chk("midrst_a_ready", a_in_ready, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_err", err, 0);
    to_drive();
    rst = 1'b0;
    fin_ready_en = 1'b1;
    tick(2);
    send_entry(16'h0001, 16'h8002, 0, 1'b0, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/svm_modality_sequencer.md
# svm_modality_sequencer

Sequences valence and arousal feature vectors from two independent upstream channels into the single `fin` port of the SVM classifier. For each entry, the valence vector always goes first and the arousal vector second. The block limits how many entries are in flight inside the SVM, tags each entry with an ID, and returns SVM results downstream in order, carrying that ID. It sits between the feature-extraction front end and `SVM`.

## Interface
Parameters:
- `NBITS`, 16, bits per feature element (matches `NBITS`).
- `F_WIDTH`, 16, feature elements per vector.
- `MAX_OUT`, 4, maximum entries in flight inside the SVM (power of two, ≥2).
- `LOG_MAX_OUT`, 2, `ceilLog2(MAX_OUT)`.
- `ID_BITS`, 8, entry ID width; the ID wraps modulo 2^ID_BITS.

Ports:
- `clk`  in  1  clock. One clock domain; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `v_in_features`  in  NBITS*F_WIDTH  valence vector, element j at `[j*NBITS +: NBITS]`.
- `v_in_valid` in 1 / `v_in_ready` out 1  valence handshake.
- `a_in_features`  in  NBITS*F_WIDTH  arousal vector.
- `a_in_valid` in 1 / `a_in_ready` out 1  arousal handshake.
- `svm_features`  out  NBITS*F_WIDTH  vector to `SVM.in_features`.
- `svm_fin_valid` out 1 / `svm_fin_ready` in 1  to/from `SVM.fin_valid`/`fin_ready`.
- `svm_valence` in 1, `svm_arousal` in 1  SVM labels.
- `svm_dout_valid` in 1 / `svm_dout_ready` out 1  SVM output handshake.
- `valence` out 1, `arousal` out 1, `dout_id` out ID_BITS  downstream result.
- `dout_valid` out 1 / `dout_ready` in 1  downstream handshake.
- `outstanding`  out  LOG_MAX_OUT+1  number of entries in flight.
- `err`  out  1  sticky protocol-error flag.
- `dout_latency`  out  32  cycles from valence issue to result (see Configuration).

## Operation
- **FSM states:** IDLE, SEND_V, LOAD_A, SEND_A. There is one `feat_q` holding register of NBITS*F_WIDTH bits.
- **IDLE**
  - `v_in_ready = (outstanding < MAX_OUT)`.
  - On the `v_in` handshake: `feat_q <= v_in_features`, go to SEND_V.
- **SEND_V**
  - `svm_fin_valid = 1`, `svm_features = feat_q`.
  - On `svm_fin_ready`: go to LOAD_A.
- **LOAD_A**
  - `a_in_ready = 1`.
  - On the `a_in` handshake: `feat_q <= a_in_features`, go to SEND_A.
- **SEND_A**
  - `svm_fin_valid = 1`.
  - On `svm_fin_ready`:
    - Push `next_id` into the tag FIFO (depth MAX_OUT).
    - `next_id <= next_id + 1`, wrapping from 2^ID_BITS-1 to 0.
    - Go to IDLE.
- **Ready outside active states:** `v_in_ready` and `a_in_ready` are 0 in every state except IDLE and LOAD_A respectively.
- **Arousal ordering:** an arousal vector offered before its valence vector has been accepted by the SVM waits; it is never reordered ahead of the valence vector.
- **Output path (combinational pass-through):**
  - `valence = svm_valence`, `arousal = svm_arousal`.
  - `dout_valid = svm_dout_valid`, `svm_dout_ready = dout_ready`.
  - `dout_id = tag FIFO head`.
  - On the downstream handshake: pop the tag FIFO.
- **Outstanding count:** `outstanding` is incremented on the SEND_A issue and decremented on the output pop.
  - Simultaneous issue and pop leaves it unchanged.
  - It never exceeds MAX_OUT, because IDLE refuses new entries at MAX_OUT.
- **Error flag:** `svm_dout_valid` asserted while `outstanding == 0` sets `err`.
  - In that case `svm_dout_ready` is still driven from `dout_ready`, no FIFO pop occurs, and `dout_id` reads 0.
  - `err` clears only on reset.

## Timing
- **Reset values:**
  - State IDLE; `feat_q`, `next_id`, `outstanding`, `err` and `dout_latency` are 0; tag FIFO is empty.
  - `svm_fin_valid = 0`, `v_in_ready = 1`, `a_in_ready = 0`.
  - `svm_features = 0`, `dout_valid` follows `svm_dout_valid`.
- **Issue timing:** the `v_in` handshake at edge N gives `svm_fin_valid = 1` from edge N.
- **Minimum cadence:** 4 cycles per entry when all readies are held high (IDLE→SEND_V→LOAD_A→SEND_A→IDLE).
- **Output latency:** the output path adds zero cycles.
- **Stall behaviour:** `svm_fin_valid` stays high and `svm_features` stays stable until `svm_fin_ready` is seen. `feat_q` changes only in IDLE and LOAD_A.
- **Reset mid-operation:**
  - Reset during any state aborts the partial entry and discards `feat_q`.
  - In-flight tags are flushed. Results returned by the SVM after reset set `err` unless the SVM itself was reset.
- **Boundary cases:**
  - With `outstanding == MAX_OUT` and a pop in the same cycle, IDLE still shows `v_in_ready = 0` that cycle; `v_in_ready` is registered on the count.
  - FIFO wrap-around: read and write pointers are LOG_MAX_OUT bits and wrap naturally.

## Configuration
- **Macro:** `SVM_SEQ_PERF_EN`.
- **Defined:**
  - A free-running 32-bit cycle counter clears on reset and wraps.
  - The counter value at the SEND_V `svm_fin_ready` handshake is stored in a timestamp FIFO parallel to the tag FIFO (depth MAX_OUT); it is pushed at SEND_A and popped with the tag FIFO.
  - `dout_latency = counter - head timestamp` (modulo 2^32), valid while `dout_valid` is high.
- **Not defined:** the counter and timestamp FIFO are absent, and `dout_latency` is tied to 0.
- **Either way:** port list and all other behaviour are identical.

## Test plan
- **Single entry:** reset; drive v = all 0x0001 and a = all 0x0002, all readies high.
  - `svm_features` shows 0x0001 vectors, then 0x0002 vectors, in consecutive active cycles.
  - The result returns with `dout_id = 0` and `outstanding` goes 0→1→0.
- **Ordering:** raise `a_in_valid` 3 cycles before `v_in_valid`.
  - `a_in_ready` stays 0 until the valence vector is accepted by the SVM; the SVM sees V before A.
- **Credit limit:** MAX_OUT=4, SVM holds `svm_dout_valid` low; push 5 entries.
  - `outstanding` reaches 4 and `v_in_ready = 0` for the 5th entry.
  - One result pop → the 5th entry is accepted on the next cycle.
- **Stall and backpressure:** hold `svm_fin_ready` low for 7 cycles in SEND_V, then `dout_ready` low for 5 cycles with `svm_dout_valid` high.
  - `svm_features` is stable and there is no pop until the handshakes occur; `dout_id` order is 0,1,2.
- **ID wrap and error:**
  - ID_BITS=2, 5 entries → `dout_id` sequence 0,1,2,3,0.
  - A spurious `svm_dout_valid` at `outstanding = 0` sets `err = 1`, which holds until `rst`.
- **Perf (with `SVM_SEQ_PERF_EN`):** an SVM model with a fixed 37-cycle valence-to-result delay gives `dout_latency = 37` for every entry. Without the macro, `dout_latency` reads 0.
